multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Moore FSM that steps the RV32 datapath through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
//  Drives the same control lines as the single-cycle decoder, plus IR/PC write enables and memory request strobes.
//  Memory handshakes have timeout counters. A retired-instruction counter is provided.
//  Sits between the IR/PC/regfile datapath and the instruction/data memory ports.
// PARAMETERS
//  TIMEOUT  16  max consecutive not-ready cycles in FETCH or MEM before trap; 0 disables timeout
//  CNT_W    32  width of retired counter
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  run         in   1      permit to start or continue fetching
//  instruction in   32     datapath IR contents; valid from the cycle after ir_write
//  imem_ready  in   1      instruction memory has data this cycle
//  dmem_ready  in   1      data memory completes access this cycle
//  imem_req    out  1      instruction fetch request
//  ir_write    out  1      load IR from imem
//  pc_write    out  1      update PC (next-PC mux selected by branch/jal_sel/jalr_sel)
//  dmem_req    out  1      data memory request
//  MemRead, MemWrite, MemToReg, ALUSrc, RegWrite, branch, jal_sel, jalr_sel  out 1 each  datapath controls
//  busy        out  1      state not IDLE and not TRAP
//  trap        out  1      sticky error
//  trap_cause  out  2      01 illegal, 10 imem timeout, 11 dmem timeout, 00 none
//  state       out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7
//  retired     out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; retired=0; wait counter=0; class reg cleared.
//   rst is sampled at any state, including mid-FETCH/MEM; requests drop the cycle after the edge.
//  Outputs are decoded from state + latched class only. No output depends combinationally on the *_ready inputs, except ir_write and pc_write as noted below.
//  Classes, decoded from {instruction[14:12], instruction[6:0]} in DECODE:
//   R    opcode 0110011, f3 in {000,001,100,101,110,111}
//   I    opcode 0010011, f3 in {000,001}
//   LD   opcode 0000011, f3=010
//   ST   opcode 0100011, f3=010
//   BR   opcode 1100011, f3 in {000,001,100,101}
//   JAL  opcode 1101111, any f3
//   JALR opcode 1100111, f3=000
//   Anything else: ILL.
//  Transitions:
//   IDLE: run=1 -> FETCH.
//   FETCH: imem_req=1. imem_ready=1 -> ir_write=1 (same cycle), -> DECODE.
//   DECODE: latch class. ILL -> TRAP (cause 01). Otherwise -> EXEC.
//   EXEC: ALUSrc=1 for I/LD/ST/JAL/JALR; jal_sel/jalr_sel per class.
//    BR: branch=1, pc_write=1, retire -> FETCH/IDLE.
//    LD/ST -> MEM. Others -> WB.
//   MEM: dmem_req=1; MemRead=1 (LD) or MemWrite=1 (ST); ALUSrc=1. On dmem_ready=1:
//    LD -> WB.
//    ST: pc_write=1, retire -> FETCH/IDLE.
//   WB: RegWrite=1 (R/I/LD/JAL/JALR); MemToReg=1 (LD); ALUSrc/jal_sel/jalr_sel held per class.
//    pc_write=1, retire -> FETCH/IDLE.
//   Completion target: FETCH if run=1 on the completing cycle, else IDLE.
//   TRAP: trap=1, all controls 0; exit only via rst.
//  Latency with ready always 1: R/I/JAL/JALR 4 cycles, LD 5, ST 4, BR 3.
//   Each not-ready cycle adds 1.
//  Timeout: wait counter clears on entry to FETCH/MEM; +1 per cycle with ready=0.
//   ready=0 while counter==TIMEOUT-1 -> TRAP, cause 10 (FETCH) or 11 (MEM).
//   ready=1 on that same cycle wins; no trap.
//  retired increments on every cycle with pc_write=1; no other retire path.
//  Control-output meanings match the single-cycle decoder. Class register is held from DECODE until retire.
// TESTING
//  1 rst; run=1; imem_ready=1; IR=0x003100B3 (add) -> states 1,2,3,5,1; RegWrite=1 only in WB; retired=1 after 4 cycles.
//  2 IR=0x0000A283 (lw); dmem_ready low 3 cycles -> MEM lasts 4 cycles with dmem_req=MemRead=1; WB has MemToReg=RegWrite=1; 8 cycles total.
//  3 IR=0x0050A023 (sw) -> MemWrite=1 in MEM; pc_write with dmem_ready; RegWrite never 1; next state FETCH.
//  4 IR=0x00208063 (beq) -> EXEC has branch=pc_write=1; 3 cycles. Repeat with run=0 at EXEC -> IDLE, busy=0.
//  5 IR=0x00000000 -> DECODE->TRAP; trap=1, cause=01; no pc_write; stays TRAP until rst, then IDLE.
//  6 imem_ready=0 for 16 cycles -> TRAP cause 10 after 16th cycle; rst asserted mid-MEM -> IDLE next edge, dmem_req=0, retired=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for an RV32 datapath.
// Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. Each memory
// wait has a timeout, and a sticky trap state can only be left through reset.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   run                 permit to start or continue fetching
//   instruction[31:0]   IR contents, valid from the cycle after ir_write
//   imem_ready          instruction memory has data this cycle
//   dmem_ready          data memory completes its access this cycle
//   imem_req, ir_write  fetch request, load IR
//   pc_write            update PC; also the single retire event
//   dmem_req            data memory request
//   MemRead .. jalr_sel datapath controls, same meaning as the single-cycle decoder
//   busy, trap          busy = not IDLE and not TRAP; trap is sticky
//   trap_cause[1:0]     01 illegal, 10 imem timeout, 11 dmem timeout
//   state[2:0]          IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7
//   retired[CNT_W-1:0]  completed instruction count, wraps
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [31:0]      instruction,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             dmem_req,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemToReg,
   output logic             ALUSrc,
   output logic             RegWrite,
   output logic             branch,
   output logic             jal_sel,
   output logic             jalr_sel,
   output logic             busy,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      ClsIll, ClsR, ClsI, ClsLd, ClsSt, ClsBr, ClsJal, ClsJalr
   } cls_e;

   // The counter only has to reach TIMEOUT-1.
   localparam int unsigned   WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

   state_e             state_q, state_d;
   cls_e               cls_q, cls_d;
   logic [1:0]         cause_q, cause_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   state_e             done_st;
   logic               timeout_hit;
   logic               uses_imm;
   logic               writes_rd;
   logic               unused_instr;

   // Only opcode and funct3 take part in classification.
   assign unused_instr = ^{instruction[31:15], instruction[11:7]};

   function automatic cls_e decode_class(input logic [2:0] f3, input logic [6:0] op);
      cls_e c;
      c = ClsIll;
      case (op)
         7'b0110011: if (f3 != 3'b010 && f3 != 3'b011) c = ClsR;
         7'b0010011: if (f3 == 3'b000 || f3 == 3'b001) c = ClsI;
         7'b0000011: if (f3 == 3'b010) c = ClsLd;
         7'b0100011: if (f3 == 3'b010) c = ClsSt;
         7'b1100011: if (f3 != 3'b010 && f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) c = ClsBr;
         7'b1101111: c = ClsJal;
         7'b1100111: if (f3 == 3'b000) c = ClsJalr;
         default:    c = ClsIll;
      endcase
      return c;
   endfunction

   assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitLast);
   assign done_st     = run ? StFetch : StIdle;
   assign uses_imm    = (cls_q == ClsI) || (cls_q == ClsLd) || (cls_q == ClsSt) ||
                        (cls_q == ClsJal) || (cls_q == ClsJalr);
   assign writes_rd   = (cls_q == ClsR) || (cls_q == ClsI) || (cls_q == ClsLd) ||
                        (cls_q == ClsJal) || (cls_q == ClsJalr);

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      cause_d = cause_q;
      wait_d  = wait_q;
      case (state_q)
         StIdle:   if (run) state_d = StFetch;
         StFetch: begin
            if (imem_ready) begin
               state_d = StDecode;
            end else if (timeout_hit) begin
               state_d = StTrap;
               cause_d = 2'b10;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDecode: begin
            cls_d = decode_class(instruction[14:12], instruction[6:0]);
            if (cls_d == ClsIll) begin
               state_d = StTrap;
               cause_d = 2'b01;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (cls_q == ClsBr)                          state_d = done_st;
            else if (cls_q == ClsLd || cls_q == ClsSt)   state_d = StMem;
            else                                         state_d = StWb;
         end
         StMem: begin
            if (dmem_ready) begin
               state_d = (cls_q == ClsLd) ? StWb : done_st;
            end else if (timeout_hit) begin
               state_d = StTrap;
               cause_d = 2'b11;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StWb:     state_d = done_st;
         StTrap:   state_d = StTrap;
         default:  state_d = StIdle;
      endcase
      // Every entry into FETCH or MEM starts a fresh wait window.
      if (state_d != state_q) wait_d = '0;
   end

   // Moore outputs; only ir_write and pc_write look at a ready input.
   always_comb begin
      imem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      dmem_req = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemToReg = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      branch   = 1'b0;
      jal_sel  = 1'b0;
      jalr_sel = 1'b0;
      case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            ir_write = imem_ready;
         end
         StExec: begin
            ALUSrc   = uses_imm;
            jal_sel  = (cls_q == ClsJal);
            jalr_sel = (cls_q == ClsJalr);
            branch   = (cls_q == ClsBr);
            pc_write = (cls_q == ClsBr);
         end
         StMem: begin
            dmem_req = 1'b1;
            MemRead  = (cls_q == ClsLd);
            MemWrite = (cls_q == ClsSt);
            ALUSrc   = 1'b1;
            pc_write = (cls_q == ClsSt) && dmem_ready;
         end
         StWb: begin
            RegWrite = writes_rd;
            MemToReg = (cls_q == ClsLd);
            ALUSrc   = uses_imm;
            jal_sel  = (cls_q == ClsJal);
            jalr_sel = (cls_q == ClsJalr);
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign retired_d = pc_write ? retired_q + CNT_W'(1) : retired_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cls_q     <= ClsIll;
         cause_q   <= 2'b00;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         cause_q   <= cause_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   assign busy       = (state_q != StIdle) && (state_q != StTrap);
   assign trap       = (state_q == StTrap);
   assign trap_cause = cause_q;
   assign state      = state_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction is expanded into an
// expected per-cycle trace (state, controls, cause) from its class and the chosen
// memory wait lengths; the trace is then replayed against the DUT cycle by cycle.
module tb_multicycle_sequencer;

   localparam int To = 16;
   localparam int ClsIll = 0, ClsR = 1, ClsI = 2, ClsLd = 3, ClsSt = 4, ClsBr = 5,
                  ClsJal = 6, ClsJalr = 7;

   typedef struct packed {
      logic imem_req, ir_write, pc_write, dmem_req, mem_read, mem_write, mem_to_reg;
      logic alu_src, reg_write, branch, jal_sel, jalr_sel, busy, trap;
   } ctrl_t;

   typedef struct {
      int         st;
      bit         ir;
      bit         dr;
      bit         rn;
      ctrl_t      c;
      logic [1:0] cause;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [31:0] instruction = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, ir_write, pc_write, dmem_req, MemRead, MemWrite, MemToReg;
   logic        ALUSrc, RegWrite, branch, jal_sel, jalr_sel, busy, trap;
   logic [1:0]  trap_cause;
   logic [2:0]  state;
   logic [31:0] retired;
   ctrl_t       obs_ctrl;

   int          checks = 0;
   int          errors = 0;
   int          exp_ret = 0;
   bit          in_idle = 1'b1;
   logic [31:0] cur_w = '0;
   ent_t        q[$];

   multicycle_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .run(run), .instruction(instruction),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .dmem_req(dmem_req),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
      .RegWrite(RegWrite), .branch(branch), .jal_sel(jal_sel), .jalr_sel(jalr_sel),
      .busy(busy), .trap(trap), .trap_cause(trap_cause), .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   assign obs_ctrl = {imem_req, ir_write, pc_write, dmem_req, MemRead, MemWrite, MemToReg,
                      ALUSrc, RegWrite, branch, jal_sel, jalr_sel, busy, trap};

   initial begin
      #400000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Instruction class straight from the opcode/funct3 table.
   function automatic int classify(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      op = w[6:0];
      f3 = w[14:12];
      case (op)
         7'b0110011: return (f3 inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111}) ? ClsR : ClsIll;
         7'b0010011: return (f3 inside {3'b000, 3'b001}) ? ClsI : ClsIll;
         7'b0000011: return (f3 == 3'b010) ? ClsLd : ClsIll;
         7'b0100011: return (f3 == 3'b010) ? ClsSt : ClsIll;
         7'b1100011: return (f3 inside {3'b000, 3'b001, 3'b100, 3'b101}) ? ClsBr : ClsIll;
         7'b1101111: return ClsJal;
         7'b1100111: return (f3 == 3'b000) ? ClsJalr : ClsIll;
         default:    return ClsIll;
      endcase
   endfunction

   // What each phase of an instruction drives, by class.
   function automatic ctrl_t exp_ctrl(input int st, input int c, input bit ir, input bit dr);
      ctrl_t v;
      bit    imm;
      bit    wr;
      v   = '0;
      imm = (c == ClsI) || (c == ClsLd) || (c == ClsSt) || (c == ClsJal) || (c == ClsJalr);
      wr  = (c == ClsR) || (c == ClsI) || (c == ClsLd) || (c == ClsJal) || (c == ClsJalr);
      v.busy = (st != 0) && (st != 7);
      v.trap = (st == 7);
      case (st)
         1: begin v.imem_req = 1'b1; v.ir_write = ir; end
         3: begin
            v.alu_src = imm; v.jal_sel = (c == ClsJal); v.jalr_sel = (c == ClsJalr);
            v.branch = (c == ClsBr); v.pc_write = (c == ClsBr);
         end
         4: begin
            v.dmem_req = 1'b1; v.mem_read = (c == ClsLd); v.mem_write = (c == ClsSt);
            v.alu_src = 1'b1; v.pc_write = (c == ClsSt) && dr;
         end
         5: begin
            v.reg_write = wr; v.mem_to_reg = (c == ClsLd); v.alu_src = imm;
            v.jal_sel = (c == ClsJal); v.jalr_sel = (c == ClsJalr); v.pc_write = 1'b1;
         end
         default: ;
      endcase
      return v;
   endfunction

   function automatic void push(input int st, input int c, input bit ir, input bit dr,
                                input bit rn, input logic [1:0] cause);
      ent_t e;
      e.st = st; e.ir = ir; e.dr = dr; e.rn = rn; e.cause = cause;
      e.c  = exp_ctrl(st, c, ir, dr);
      q.push_back(e);
   endfunction

   function automatic void push_trap(input logic [1:0] cause);
      for (int i = 0; i < 4; i++) push(7, ClsIll, rb(), rb(), rb(), cause);
   endfunction

   // Expected trace of one instruction: iw/dw not-ready cycles in FETCH/MEM.
   task automatic build(input logic [31:0] w, input int iw, input int dw, input bit run_end);
      int c;
      c     = classify(w);
      cur_w = w;
      q.delete();
      if (in_idle) begin
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) push(0, c, rb(), rb(), 1'b0, 2'b00);
         push(0, c, rb(), rb(), 1'b1, 2'b00);
      end
      for (int i = 0; i < iw && i < To; i++) push(1, c, 1'b0, rb(), 1'b1, 2'b00);
      if (iw >= To) begin push_trap(2'b10); return; end
      push(1, c, 1'b1, rb(), 1'b1, 2'b00);
      push(2, c, rb(), rb(), 1'b1, 2'b00);
      if (c == ClsIll) begin push_trap(2'b01); return; end
      if (c == ClsBr) begin
         push(3, c, rb(), rb(), run_end, 2'b00);
         in_idle = !run_end;
         return;
      end
      push(3, c, rb(), rb(), 1'b1, 2'b00);
      if (c == ClsLd || c == ClsSt) begin
         for (int i = 0; i < dw && i < To; i++) push(4, c, rb(), 1'b0, 1'b1, 2'b00);
         if (dw >= To) begin push_trap(2'b11); return; end
         if (c == ClsSt) begin
            push(4, c, rb(), 1'b1, run_end, 2'b00);
            in_idle = !run_end;
            return;
         end
         push(4, c, rb(), 1'b1, 1'b1, 2'b00);
      end
      push(5, c, rb(), rb(), run_end, 2'b00);
      in_idle = !run_end;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Replay up to 'limit' rows of the expected trace, one clock per row.
   task automatic play(input int limit);
      for (int k = 0; k < q.size() && k < limit; k++) begin
         @(negedge clk);
         run         = q[k].rn;
         imem_ready  = q[k].ir;
         dmem_ready  = q[k].dr;
         instruction = (q[k].st == 1) ? $urandom : cur_w;
         #1;
         chk($sformatf("state[%0d]", k), 64'(state), 64'(q[k].st));
         chk($sformatf("ctrl[%0d]", k), 64'(obs_ctrl), 64'(q[k].c));
         chk($sformatf("cause[%0d]", k), 64'(trap_cause), 64'(q[k].cause));
         chk($sformatf("retired[%0d]", k), 64'(retired), 64'(exp_ret));
         if (q[k].c.pc_write) exp_ret++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; run = rb(); imem_ready = rb(); dmem_ready = rb();
      @(negedge clk);
      rst = 1'b0; run = 1'b0;
      #1;
      exp_ret = 0;
      in_idle = 1'b1;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_ctrl", 64'(obs_ctrl), 64'd0);
      chk("rst_cause", 64'(trap_cause), 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
   endtask

   function automatic logic [31:0] rand_legal();
      logic [31:0] w;
      do begin
         w = $urandom;
         case ($urandom_range(0, 6))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            3: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1101111;
            default: begin w[6:0] = 7'b1100111; w[14:12] = 3'b000; end
         endcase
      end while (classify(w) == ClsIll);
      return w;
   endfunction

   initial begin
      do_reset();
      // Directed: add, lw with 3 wait cycles, sw, beq, beq ending with run=0.
      build(32'h003100B3, 0, 0, 1'b1); play(100);
      build(32'h0000A283, 0, 3, 1'b1); play(100);
      build(32'h0050A023, 0, 0, 1'b1); play(100);
      build(32'h00208063, 0, 0, 1'b1); play(100);
      build(32'h00208063, 0, 0, 1'b0); play(100);
      // Timeout boundaries: last allowed wait cycle ends with ready, no trap.
      build(32'h003100B3, 15, 0, 1'b1); play(100);
      build(32'h0000A283, 0, 15, 1'b1); play(100);
      build(32'h0050A023, 2, 15, 1'b0); play(100);
      // Random legal instructions with random waits and run at completion.
      for (int n = 0; n < 60; n++) begin
         build(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), rb());
         play(100);
      end
      // Illegal instruction traps with cause 01 and holds until reset.
      build(32'h00000000, 1, 0, 1'b1); play(100);
      do_reset();
      build(32'h0000B2B3 & 32'hFFFF8FFF | 32'h00002000, 0, 0, 1'b1); play(100);
      do_reset();
      // Fetch timeout after the 16th not-ready cycle.
      build(32'h003100B3, 16, 0, 1'b1); play(100);
      do_reset();
      // Data timeout.
      build(32'h0000A283, 0, 16, 1'b1); play(100);
      do_reset();
      // Reset in the middle of a MEM wait.
      build(32'h003100B3, 0, 0, 1'b1); play(100);
      build(32'h0000A283, 0, 10, 1'b1); play(5);
      chk("pre_rst_mem", 64'(state), 64'd4);
      do_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
